// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock and flush control for the D stage, plus
// the multiply/divide unit busy counter.
//
// Handshake note: there is no valid/ready pair here. stall holds PC and the
// F/D register (pc_en = fd_en = ~stall) and bubbles D/E (de_clr). Req is the
// exception/interrupt flush and wins over every hazard in the same cycle.
//
// MULT_CYC and DIV_CYC must lie in 1..15 so they fit the 4-bit md_cnt.
module hazard_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  // D-stage operand usage
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_tuse_rs,
  input  logic [1:0] D_tuse_rt,
  input  logic       D_is_md,
  input  logic       D_is_eret,
  // producers in E and M
  input  logic [4:0] E_A3,
  input  logic [1:0] E_tnew,
  input  logic [4:0] M_A3,
  input  logic [1:0] M_tnew,
  input  logic       E_md_start,
  input  logic       E_md_is_div,
  input  logic       E_mtc0_epc,
  input  logic       M_mtc0_epc,
  input  logic       Req,
  // pipeline control
  output logic       stall,
  output logic       pc_en,
  output logic       fd_en,
  output logic       fd_clr,
  output logic       de_clr,
  output logic       em_clr,
  output logic       mw_clr,
  // MDU status
  output logic       md_busy,
  output logic [3:0] md_cnt,
  output logic       md_done
);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

  md_state_e  state_q;
  logic [3:0] cnt_q;

  logic rs_haz;
  logic rt_haz;
  logic md_haz;
  logic eret_haz;
  logic stall_raw;

  // Hazard detection: a source register is hazardous while a producer in E
  // or M still needs more cycles than the consumer can wait. $0 never hazards.
  always_comb begin
    rs_haz    = 1'b0;
    rt_haz    = 1'b0;
    md_haz    = 1'b0;
    eret_haz  = 1'b0;
    stall_raw = 1'b0;
    rs_haz = (D_rs != 5'd0) &&
             (((D_rs == E_A3) && (E_tnew > D_tuse_rs)) ||
              ((D_rs == M_A3) && (M_tnew > D_tuse_rs)));
    rt_haz = (D_rt != 5'd0) &&
             (((D_rt == E_A3) && (E_tnew > D_tuse_rt)) ||
              ((D_rt == M_A3) && (M_tnew > D_tuse_rt)));
    // The MDU hazard covers the start cycle itself (E_md_start) so an MD op
    // right behind mult/div never slips in before md_busy rises.
    md_haz    = D_is_md && (E_md_start || (state_q == MD_BUSY));
    eret_haz  = D_is_eret && (E_mtc0_epc || M_mtc0_epc);
    stall_raw = rs_haz || rt_haz || md_haz || eret_haz;
  end

  // Req overrides stalls: the whole front of the pipe is flushed instead.
  assign stall  = stall_raw && !Req;
  assign pc_en  = !stall;
  assign fd_en  = !stall;
  assign de_clr = stall || Req;
  assign fd_clr = Req;
  assign em_clr = Req;
  assign mw_clr = Req;

  assign md_busy = (state_q == MD_BUSY);
  assign md_cnt  = cnt_q;
  assign md_done = (state_q == MD_BUSY) && (cnt_q == 4'd1);

  // MDU FSM: load the op latency on a non-flushed start, count down to 1,
  // then return to idle. Req never aborts a running count; reset does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (E_md_start && !Req) begin
            state_q <= MD_BUSY;
            cnt_q   <= E_md_is_div ? DIV_LOAD : MULT_LOAD;
          end
        end
        MD_BUSY: begin
          // A start seen here is ignored; the count simply continues.
          if (cnt_q <= 4'd1) begin
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus for hazard_ctrl with a
// queue-based scoreboard and a cycle-indexed reference model of the MDU.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic       D_is_md, D_is_eret, E_md_start, E_md_is_div;
  logic       E_mtc0_epc, M_mtc0_epc, Req;
  logic       stall, pc_en, fd_en, fd_clr, de_clr, em_clr, mw_clr;
  logic       md_busy, md_done;
  logic [3:0] md_cnt;

  hazard_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_is_md(D_is_md), .D_is_eret(D_is_eret),
    .E_A3(E_A3), .E_tnew(E_tnew), .M_A3(M_A3), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
    .E_mtc0_epc(E_mtc0_epc), .M_mtc0_epc(M_mtc0_epc), .Req(Req),
    .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .fd_clr(fd_clr),
    .de_clr(de_clr), .em_clr(em_clr), .mw_clr(mw_clr),
    .md_busy(md_busy), .md_cnt(md_cnt), .md_done(md_done)
  );

  // ---------------- scoreboard ----------------
  // Bit order: stall pc_en fd_en fd_clr de_clr em_clr mw_clr busy cnt[3:0] done
  logic [12:0] exp_q[$];
  string       name_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model: the MDU is described by the last cycle index in which it
  // is busy. Cycle k is the period between edge k-1 and edge k.
  int k       = 0;
  int end_cyc = -1;

  function automatic logic hz(input logic [4:0] r, input logic [1:0] tuse);
    return (r != 5'd0) &&
           ((r == E_A3 && E_tnew > tuse) || (r == M_A3 && M_tnew > tuse));
  endfunction

  // Compute the expected outputs for the current cycle, queue them, then let
  // one clock edge pass and advance the model across it.
  task automatic step(input string nm);
    logic busy, hazard, st;
    int   cnt;
    busy   = (k <= end_cyc);
    cnt    = busy ? (end_cyc - k + 1) : 0;
    hazard = hz(D_rs, D_tuse_rs) || hz(D_rt, D_tuse_rt) ||
             (D_is_md && (E_md_start || busy)) ||
             (D_is_eret && (E_mtc0_epc || M_mtc0_epc));
    st     = hazard && !Req;
    exp_q.push_back({st, !st, !st, Req, st || Req, Req, Req,
                     busy, 4'(cnt), (busy && cnt == 1)});
    name_q.push_back(nm);
    @(posedge clk);
    if (reset) end_cyc = k;
    else if (!busy && E_md_start && !Req)
      end_cyc = k + (E_md_is_div ? DIV_N : MULT_N);
    k++;
    #1;
  endtask

  task automatic clear_inputs();
    D_rs = 0; D_rt = 0; D_tuse_rs = 3; D_tuse_rt = 3; D_is_md = 0;
    D_is_eret = 0; E_A3 = 0; E_tnew = 0; M_A3 = 0; M_tnew = 0;
    E_md_start = 0; E_md_is_div = 0; E_mtc0_epc = 0; M_mtc0_epc = 0; Req = 0;
  endtask

  // Monitor: outputs are meaningful every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] exp_v, act_v;
      string       nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {stall, pc_en, fd_en, fd_clr, de_clr, em_clr, mw_clr,
               md_busy, md_cnt, md_done};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL %s cyc=%0d: got %b want %b (stall pc fd fdclr declr emclr mwclr busy cnt done)",
                 nm, k, act_v, exp_v);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    D_tuse_rs = 0; D_tuse_rt = 0;   // all-zero inputs during reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    end_cyc = -1;
    k = 0;

    // Reset state with all-zero inputs
    step("reset_zero");
    // Combinational path during reset, plus start ignored under reset
    D_rs = 5'd8; E_A3 = 5'd8; E_tnew = 2'd2; E_md_start = 1; E_md_is_div = 1;
    step("reset_comb");
    clear_inputs();
    reset = 1'b0;
    step("idle_after_reset");

    // Load-use: lw in E, then in M, then result ready
    E_A3 = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd0;
    step("lw_in_E");
    E_A3 = 0; E_tnew = 0; M_A3 = 5'd8; M_tnew = 2'd1;
    step("lw_in_M");
    M_tnew = 2'd0;
    step("lw_done");
    // rt side, tuse exactly equal to tnew is not a hazard
    clear_inputs();
    D_rt = 5'd9; D_tuse_rt = 2'd1; E_A3 = 5'd9; E_tnew = 2'd1;
    step("rt_equal_tuse");
    E_tnew = 2'd2;
    step("rt_hazard");

    // div with MD instruction waiting in D
    clear_inputs();
    D_is_md = 1; E_md_start = 1; E_md_is_div = 1;
    step("div_start");
    E_md_start = 0; E_md_is_div = 0;
    for (int i = 0; i < DIV_N + 1; i++) step("div_busy");
    clear_inputs();

    // Req beats a hazard; start under Req is dropped
    E_A3 = 5'd8; E_tnew = 2'd2; D_rs = 5'd8; D_tuse_rs = 2'd0; Req = 1;
    E_md_start = 1;
    step("req_priority");
    clear_inputs();
    step("req_no_start");

    // eret behind mtc0 EPC; $0 never hazards
    D_is_eret = 1; E_mtc0_epc = 1;
    step("eret_E");
    E_mtc0_epc = 0; M_mtc0_epc = 1;
    step("eret_M");
    clear_inputs();
    D_rs = 0; E_A3 = 0; E_tnew = 2'd2; D_tuse_rs = 2'd0;
    step("zero_reg");
    clear_inputs();

    // mult aborted by reset at md_cnt=3
    E_md_start = 1;
    step("mult_start");
    E_md_start = 0;
    step("mult_5");
    step("mult_4");
    reset = 1;
    step("mult_3_reset");
    reset = 0;
    step("mult_aborted");

    // mult survives Req (and a stray start) at md_cnt=3
    E_md_start = 1;
    step("mult2_start");
    E_md_start = 0;
    step("mult2_5");
    step("mult2_4");
    Req = 1; E_md_start = 1; E_md_is_div = 1;
    step("mult2_3_req");
    clear_inputs();
    for (int i = 0; i < 4; i++) step("mult2_tail");

    // Random: narrow register range so matches are frequent
    for (int i = 0; i < 600; i++) begin
      D_rs        = 5'($urandom_range(0, 3));
      D_rt        = 5'($urandom_range(0, 3));
      D_tuse_rs   = 2'($urandom_range(0, 3));
      D_tuse_rt   = 2'($urandom_range(0, 3));
      E_A3        = 5'($urandom_range(0, 3));
      M_A3        = 5'($urandom_range(0, 3));
      E_tnew      = 2'($urandom_range(0, 3));
      M_tnew      = 2'($urandom_range(0, 3));
      D_is_md     = ($urandom_range(0, 3) == 0);
      D_is_eret   = ($urandom_range(0, 7) == 0);
      E_mtc0_epc  = ($urandom_range(0, 3) == 0);
      M_mtc0_epc  = ($urandom_range(0, 3) == 0);
      E_md_start  = ($urandom_range(0, 5) == 0);
      E_md_is_div = 1'($urandom_range(0, 1));
      Req         = ($urandom_range(0, 9) == 0);
      reset       = ($urandom_range(0, 59) == 0);
      step("random");
    end
    reset = 0;
    clear_inputs();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
